// File: rtl/hash_block_streamer_if.sv
// Bus bundle for hash_block_streamer: padded-message input and the word stream toward the compression core.
interface hash_block_streamer_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1023:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [3:0]        out_idx;
    logic              out_block;
    logic              out_last;

    // Handshake: a transfer occurs on a rising edge where valid and ready are both high; the valid side holds its payload stable until then.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_block, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_block, out_last
    );
endinterface

// File: rtl/hash_block_streamer.sv
// Captures one 1024-bit SHA-256 padded message and streams it as 32 big-endian words over two blocks.
// Padding check (pad_err) is enabled by defining HASH_STREAM_PAD_CHECK_EN; otherwise every message streams.
module hash_block_streamer #(
    parameter int MSG_LEN_BITS = 640,
    parameter int WORD_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hash_block_streamer_if.slave bus,
    output logic                 pad_err,
    output logic [15:0]          msg_cnt,
    output logic                 o_dbg_state,
    output logic                 o_dbg_pad_ok
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t        r_state;
    logic [1023:0] r_buf;
    logic [4:0]    r_cnt;
    logic          r_pad_err;
    logic [15:0]   r_msg_cnt;
    logic          w_pad_ok;
    logic          w_accept_ok;

    // Marker at bit 383, zero fill down to bit 64, then the 64-bit length field.
    assign w_pad_ok = bus.in_data[383]
                   && (bus.in_data[382:64] == '0)
                   && (bus.in_data[63:0] == 64'(MSG_LEN_BITS));

`ifdef HASH_STREAM_PAD_CHECK_EN
    assign w_accept_ok = w_pad_ok;
`else
    assign w_accept_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_pad_err <= 1'b0;
            r_msg_cnt <= '0;
        end else begin
            r_pad_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_accept_ok) begin
                            r_buf   <= bus.in_data;
                            r_cnt   <= '0;
                            r_state <= ST_STREAM;
                        end else begin
                            r_pad_err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (bus.out_ready) begin
                        // The buffer drains to all-zero after 32 shifts, so IDLE presents out_word=0.
                        r_buf <= {r_buf[1023-WORD_W:0], {WORD_W{1'b0}}};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state   <= ST_IDLE;
                            r_msg_cnt <= r_msg_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_STREAM);
    assign bus.out_word  = r_buf[1023 -: WORD_W];
    assign bus.out_idx   = r_cnt[3:0];
    assign bus.out_block = r_cnt[4];
    assign bus.out_last  = (r_state == ST_STREAM) && (r_cnt == 5'd31);

    assign pad_err      = r_pad_err;
    assign msg_cnt      = r_msg_cnt;
    assign o_dbg_state  = r_state;
    assign o_dbg_pad_ok = w_pad_ok;
endmodule
